// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: sequences multi-frame captures from the raw-byte camera reader.
// Aligns to the first full frame, gates whole frames downstream, checks line
// geometry and reports ok / timeout / abort / geometry status.
// Optional build macro CAM_CAPTURE_DECIMATE_EN adds skip_n and a SKIP state that
// drops skip_n full frames after each captured frame.
module cam_capture_ctrl #(
    parameter int EXP_PIX        = 640,
    parameter int EXP_LINES      = 480,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 16
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_frames,
    input  logic             abort,
    input  logic             vsync,
    output logic             cam_start,
    input  logic             in_valid,
    input  logic [7:0]       in_pixel,
`ifdef CAM_CAPTURE_DECIMATE_EN
    input  logic [3:0]       skip_n,
`endif
    output logic             out_valid,
    output logic [7:0]       out_pixel,
    output logic             out_sof,
    output logic             busy,
    output logic             done,
    output logic             sts_ok,
    output logic             sts_timeout,
    output logic             sts_abort,
    output logic             sts_geom_err,
    output logic [CNT_W-1:0] frames_done
);

    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready high
    // ARM     | reader started, waiting for the end of the current (partial) frame
    // SYNC    | waiting for vsync fall, the start of a full frame
    // CAPTURE | forwarding pixels and checking geometry
    // SKIP    | (decimation builds) dropping skip_n full frames
`ifdef CAM_CAPTURE_DECIMATE_EN
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_SKIP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE} state_t;
`endif

    localparam int PIX_W  = $clog2(EXP_PIX + 2);
    localparam int LINE_W = $clog2(EXP_LINES + 2);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               vs_s1, vs_s2, vs_d;
    logic               in_valid_d;
    logic [CNT_W-1:0]   cnt_lat;
    logic [PIX_W-1:0]   pix_cnt;
    logic [LINE_W-1:0]  line_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic               geom_err;
    logic               sof_pending;
`ifdef CAM_CAPTURE_DECIMATE_EN
    logic [3:0]         skip_lat;
    logic [3:0]         skip_left;
`endif

    logic               vs_rise, vs_fall, in_fall, activity, wd_expired;
    logic               pix_bad, line_bad, frame_err;
    logic [CNT_W-1:0]   frames_nxt;

    assign vs_rise    = vs_s2 & ~vs_d;
    assign vs_fall    = ~vs_s2 & vs_d;
    assign in_fall    = in_valid_d & ~in_valid;
    assign activity   = in_valid | vs_rise | vs_fall;
    assign wd_expired = (wd_cnt == '0) && !activity;
    // A line ending on the frame-end cycle still contributes to the frame verdict.
    assign pix_bad    = in_fall && (pix_cnt != PIX_W'(EXP_PIX));
    assign line_bad   = (line_cnt != LINE_W'(EXP_LINES));
    assign frame_err  = geom_err | pix_bad | line_bad;
    assign frames_nxt = frames_done + CNT_W'(1);

    // vsync synchroniser plus edge-detect register, and in_valid history for line ends
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_d       <= 1'b0;
            in_valid_d <= 1'b0;
        end else begin
            vs_s1      <= vsync;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            in_valid_d <= in_valid;
        end
    end

    // Pixel path: fixed one-cycle latency, valid gated to the CAPTURE state
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_pixel <= 8'd0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            out_pixel <= in_pixel;
            out_valid <= in_valid && (state == S_CAPTURE);
            out_sof   <= in_valid && (state == S_CAPTURE) && sof_pending;
        end
    end

    // Capture sequencer: command accept, frame alignment, geometry, watchdog, status
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            cam_start    <= 1'b0;
            done         <= 1'b0;
            sts_ok       <= 1'b0;
            sts_timeout  <= 1'b0;
            sts_abort    <= 1'b0;
            sts_geom_err <= 1'b0;
            frames_done  <= '0;
            cnt_lat      <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            wd_cnt       <= '0;
            geom_err     <= 1'b0;
            sof_pending  <= 1'b0;
`ifdef CAM_CAPTURE_DECIMATE_EN
            skip_lat     <= 4'd0;
            skip_left    <= 4'd0;
`endif
        end else begin
            cam_start <= 1'b0;
            done      <= 1'b0;
            if (state == S_IDLE) begin
                cmd_ready <= 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cnt_lat      <= (cmd_frames == '0) ? CNT_W'(1) : cmd_frames;
`ifdef CAM_CAPTURE_DECIMATE_EN
                    skip_lat     <= skip_n;
`endif
                    sts_ok       <= 1'b0;
                    sts_timeout  <= 1'b0;
                    sts_abort    <= 1'b0;
                    sts_geom_err <= 1'b0;
                    frames_done  <= '0;
                    geom_err     <= 1'b0;
                    sof_pending  <= 1'b0;
                    wd_cnt       <= WD_LOAD;
                    cam_start    <= 1'b1;
                    cmd_ready    <= 1'b0;
                    busy         <= 1'b1;
                    state        <= S_ARM;
                end
            end else if (abort) begin
                sts_abort <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
            end else if (wd_expired) begin
                sts_timeout <= 1'b1;
                done        <= 1'b1;
                busy        <= 1'b0;
                cmd_ready   <= 1'b1;
                state       <= S_IDLE;
            end else begin
                wd_cnt <= activity ? WD_LOAD : wd_cnt - WD_W'(1);
                case (state)
                    S_ARM: begin
                        if (vs_rise) state <= S_SYNC;
                    end
                    S_SYNC: begin
                        if (vs_fall) begin
                            pix_cnt     <= '0;
                            line_cnt    <= '0;
                            sof_pending <= 1'b1;
                            state       <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (in_valid) begin
                            pix_cnt <= pix_cnt + PIX_W'(1);
                            if (sof_pending) sof_pending <= 1'b0;
                        end else if (in_fall) begin
                            if (pix_bad) geom_err <= 1'b1;
                            line_cnt <= line_cnt + LINE_W'(1);
                            pix_cnt  <= '0;
                        end
                        if (vs_rise) begin
                            geom_err    <= frame_err;
                            frames_done <= frames_nxt;
                            if (frames_nxt == cnt_lat) begin
                                sts_ok       <= !frame_err;
                                sts_geom_err <= frame_err;
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                cmd_ready    <= 1'b1;
                                state        <= S_IDLE;
`ifdef CAM_CAPTURE_DECIMATE_EN
                            end else if (skip_lat != 4'd0) begin
                                skip_left <= skip_lat;
                                state     <= S_SKIP;
`endif
                            end else begin
                                state <= S_SYNC;
                            end
                        end
                    end
`ifdef CAM_CAPTURE_DECIMATE_EN
                    S_SKIP: begin
                        if (vs_rise) begin
                            skip_left <= skip_left - 4'd1;
                            if (skip_left == 4'd1) state <= S_SYNC;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed bench for cam_capture_ctrl with a 4x8 frame geometry.
module tb_cam_capture_ctrl;
    localparam int CNT_W = 16;

    logic             pclk = 1'b0;
    logic             rst_n, cmd_valid, abort, vsync, in_valid;
    logic [CNT_W-1:0] cmd_frames;
    logic [7:0]       in_pixel;
    logic             cmd_ready, cam_start, out_valid, out_sof, busy, done;
    logic             sts_ok, sts_timeout, sts_abort, sts_geom_err;
    logic [7:0]       out_pixel;
    logic [CNT_W-1:0] frames_done;
`ifdef CAM_CAPTURE_DECIMATE_EN
    logic [3:0]       skip_n;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_ov = 0, n_sof = 0, n_done = 0, n_start = 0, n_pix_bad = 0;
    logic [7:0] last_in = 8'd0;
    logic [33:0] all_out;

    assign all_out = {cmd_ready, cam_start, out_valid, out_pixel, out_sof, busy, done,
                      sts_ok, sts_timeout, sts_abort, sts_geom_err, frames_done};

    always #5 pclk = ~pclk;

    cam_capture_ctrl #(
        .EXP_PIX(8), .EXP_LINES(4), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_frames(cmd_frames), .abort(abort), .vsync(vsync), .cam_start(cam_start),
        .in_valid(in_valid), .in_pixel(in_pixel),
`ifdef CAM_CAPTURE_DECIMATE_EN
        .skip_n(skip_n),
`endif
        .out_valid(out_valid), .out_pixel(out_pixel), .out_sof(out_sof),
        .busy(busy), .done(done), .sts_ok(sts_ok), .sts_timeout(sts_timeout),
        .sts_abort(sts_abort), .sts_geom_err(sts_geom_err), .frames_done(frames_done)
    );

    always @(posedge pclk) last_in <= in_pixel;

    always @(negedge pclk) begin
        if (out_valid) begin
            n_ov++;
            if (out_pixel !== last_in) n_pix_bad++;
        end
        if (out_sof)   n_sof++;
        if (done)      n_done++;
        if (cam_start) n_start++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic [CNT_W-1:0] n);
        int k;
        k = 0;
        cmd_frames = n;
        cmd_valid  = 1'b1;
        while (!cmd_ready && k < 20) begin
            tick(1);
            k++;
        end
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_line(input int len);
        in_valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            in_pixel = 8'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input int bad_line, input int bad_len);
        vsync = 1'b0;
        tick(6);
        for (int l = 0; l < 4; l++) send_line((l == bad_line) ? bad_len : 8);
        vsync = 1'b1;
        tick(8);
    endtask

    // Partial frame already running when the command lands, then it ends.
    task automatic start_with_partial(input logic [CNT_W-1:0] n);
        vsync = 1'b0;
        tick(6);
        issue(n);
        send_line(8);
        send_line(8);
        vsync = 1'b1;
        tick(8);
    endtask

    typedef struct {
        logic [CNT_W-1:0] frames;
        int               n_full;
        int               bad_frame;
        int               bad_len;
        int               exp_ov;
        int               exp_sof;
        int               exp_fd;
        logic             exp_ok;
        logic             exp_geom;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b_ov, b_sof, b_done, b_start, b_pix, k;

        vecs[0] = '{frames: 16'd2, n_full: 3, bad_frame: -1, bad_len: 8, exp_ov: 64, exp_sof: 2, exp_fd: 2, exp_ok: 1'b1, exp_geom: 1'b0};
        vecs[1] = '{frames: 16'd1, n_full: 2, bad_frame: 0,  bad_len: 7, exp_ov: 31, exp_sof: 1, exp_fd: 1, exp_ok: 1'b0, exp_geom: 1'b1};
        vecs[2] = '{frames: 16'd0, n_full: 2, bad_frame: -1, bad_len: 8, exp_ov: 32, exp_sof: 1, exp_fd: 1, exp_ok: 1'b1, exp_geom: 1'b0};
        vecs[3] = '{frames: 16'd3, n_full: 3, bad_frame: 2,  bad_len: 9, exp_ov: 97, exp_sof: 3, exp_fd: 3, exp_ok: 1'b0, exp_geom: 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; vsync = 1'b0;
        in_valid = 1'b0; in_pixel = 8'd0; cmd_frames = '0;
`ifdef CAM_CAPTURE_DECIMATE_EN
        skip_n = 4'd0;
`endif
        #12;
        check("reset_outputs", 64'(all_out), 64'd0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        tick(2);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Table-driven whole-capture scenarios
        foreach (vecs[v]) begin
            b_ov = n_ov; b_sof = n_sof; b_done = n_done; b_start = n_start; b_pix = n_pix_bad;
            start_with_partial(vecs[v].frames);
            for (int f = 0; f < vecs[v].n_full; f++)
                send_frame((f == vecs[v].bad_frame) ? 1 : -1, vecs[v].bad_len);
            check($sformatf("v%0d_out_valid_count", v), 64'(n_ov - b_ov), 64'(vecs[v].exp_ov));
            check($sformatf("v%0d_sof_count", v), 64'(n_sof - b_sof), 64'(vecs[v].exp_sof));
            check($sformatf("v%0d_done_pulses", v), 64'(n_done - b_done), 64'd1);
            check($sformatf("v%0d_cam_start_cycles", v), 64'(n_start - b_start), 64'd1);
            check($sformatf("v%0d_pixel_data", v), 64'(n_pix_bad - b_pix), 64'd0);
            check($sformatf("v%0d_sts_ok", v), 64'(sts_ok), 64'(vecs[v].exp_ok));
            check($sformatf("v%0d_sts_geom_err", v), 64'(sts_geom_err), 64'(vecs[v].exp_geom));
            check($sformatf("v%0d_frames_done", v), 64'(frames_done), 64'(vecs[v].exp_fd));
            check($sformatf("v%0d_sts_timeout_abort", v), 64'({sts_timeout, sts_abort}), 64'd0);
            check($sformatf("v%0d_idle_after", v), 64'({busy, cmd_ready}), 64'b01);
        end

        // Watchdog: vsync held low after arm, no pixels
        vsync = 1'b0;
        tick(6);
        issue(16'd1);
        k = 0;
        for (int i = 1; i <= 150; i++) begin
            tick(1);
            if (done) begin
                k = i;
                break;
            end
        end
        check("timeout_latency", 64'(k), 64'd100);
        check("timeout_status", 64'({sts_timeout, sts_ok, sts_abort}), 64'b100);
        tick(1);
        check("timeout_busy_next", 64'({busy, done}), 64'b00);

        // Abort mid-line in CAPTURE, then a new command one cycle later
        start_with_partial(16'd1);
        vsync = 1'b0;
        tick(6);
        in_valid = 1'b1;
        tick(4);
        check("abort_pre_out_valid", 64'(out_valid), 64'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_done", 64'(done), 64'd1);
        check("abort_status", 64'({sts_abort, sts_ok, sts_timeout}), 64'b100);
        check("abort_frames_done", 64'(frames_done), 64'd0);
        cmd_frames = 16'd1;
        cmd_valid  = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        check("abort_out_valid_drop", 64'(out_valid), 64'd0);
        check("abort_reaccept", 64'({busy, cam_start, sts_abort}), 64'b110);
        in_valid = 1'b0;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        vsync = 1'b1;
        tick(8);

        // Abort on the same cycle as the frame-end vsync rise
        start_with_partial(16'd1);
        vsync = 1'b0;
        tick(6);
        for (int l = 0; l < 4; l++) send_line(8);
        vsync = 1'b1;
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_vs_done", 64'(done), 64'd1);
        check("abort_vs_status", 64'({sts_abort, sts_ok, sts_geom_err}), 64'b100);
        check("abort_vs_frames_done", 64'(frames_done), 64'd0);
        tick(8);

        // Asynchronous reset mid-line
        b_start = n_start;
        start_with_partial(16'd2);
        vsync = 1'b0;
        tick(6);
        in_valid = 1'b1;
        tick(3);
        check("rst_pre_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'(all_out), 64'd0);
        tick(3);
        check("rst_held_outputs", 64'(all_out), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick(5);
        check("rst_after_idle", 64'({busy, cmd_ready}), 64'b01);
        check("rst_no_restart", 64'(n_start - b_start), 64'd1);

`ifdef CAM_CAPTURE_DECIMATE_EN
        // Decimation: capture frame 1, skip frame 2, capture frame 3
        begin
            int f_ov[3];
            skip_n = 4'd1;
            b_ov = n_ov; b_done = n_done;
            start_with_partial(16'd2);
            skip_n = 4'd0;
            for (int f = 0; f < 3; f++) begin
                k = n_ov;
                send_frame(-1, 8);
                f_ov[f] = n_ov - k;
            end
            send_frame(-1, 8);
            check("dec_frame1_fwd", 64'(f_ov[0]), 64'd32);
            check("dec_frame2_gated", 64'(f_ov[1]), 64'd0);
            check("dec_frame3_fwd", 64'(f_ov[2]), 64'd32);
            check("dec_total", 64'(n_ov - b_ov), 64'd64);
            check("dec_frames_done", 64'(frames_done), 64'd2);
            check("dec_status", 64'({sts_ok, sts_geom_err}), 64'b10);
            check("dec_done_pulses", 64'(n_done - b_done), 64'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
